// File: rtl/nonce_feeder.sv
// nonce_feeder
//   Holds an 80-byte block header loaded by the host and serves it word-by-word
//   to an external double-SHA256 hasher. The last header word is replaced by a
//   nonce register that is stepped after every miss until a hash with enough
//   leading zero bits turns up or the 32-bit nonce space runs out.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   load_valid/data   host header byte stream (bytes 0..79, in order)
//   load_ready        header bytes accepted (IDLE only)
//   go, clear         start/resume the sweep; abandon the job
//   zbits             required number of leading zero hash bits
//   h_start           one-cycle start pulse to the hasher
//   h_rq, h_addr      hasher word request (rising edge) and word index
//   h_data, h_rdy     served word and its one-cycle strobe
//   h_hash, h_done    hasher result (bit 255 = MSB) and completion flag
//   found, exhausted  job status
//   busy              sweep in progress (ARM/HASH/CHECK)
//   nonce             current nonce register
module nonce_feeder #(
    parameter logic [31:0] NONCE_STEP = 32'd1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_valid,
    input  logic [7:0]   load_data,
    output logic         load_ready,
    input  logic         go,
    input  logic         clear,
    input  logic [7:0]   zbits,
    output logic         h_start,
    input  logic         h_rq,
    input  logic [4:0]   h_addr,
    output logic [31:0]  h_data,
    output logic         h_rdy,
    input  logic [255:0] h_hash,
    input  logic         h_done,
    output logic         found,
    output logic         exhausted,
    output logic         busy,
    output logic [31:0]  nonce
);

    typedef enum logic [2:0] {
        IDLE, READY, ARM, HASH, CHECK, FOUND, EXHAUSTED
    } state_e;

    // Above this value one more step would wrap past 0xFFFFFFFF.
    localparam logic [31:0] NONCE_LAST = 32'hFFFF_FFFF - NONCE_STEP;

    state_e        state_q, state_d;
    logic [6:0]    cnt_q, cnt_d;
    logic [31:0]   nonce_q, nonce_d;
    logic          hit_q, hit_d;
    logic          rq_prev_q;
    logic          h_rdy_q, h_rdy_d;
    logic [31:0]   h_data_q, h_data_d;

    // Header words 0..18; bytes 76..79 live only in the nonce register.
    logic [31:0]   hdr_q [0:18];

    logic          load_fire;
    logic [255:0]  hit_mask;
    logic          at_last;
    logic [31:0]   word_sel;

    assign load_fire = load_valid && (state_q == IDLE);
    // Top zbits bits set; zbits=0 gives an empty mask, i.e. always a hit.
    assign hit_mask  = ~({256{1'b1}} >> zbits);
    assign at_last   = (nonce_q > NONCE_LAST);

    // Header storage is never reset; only accepted IDLE bytes write it.
    always_ff @(posedge clk) begin
        if (!rst && load_fire && (cnt_q < 7'd76)) begin
            case (cnt_q[1:0])
                2'd0: hdr_q[cnt_q[6:2]][31:24] <= load_data;
                2'd1: hdr_q[cnt_q[6:2]][23:16] <= load_data;
                2'd2: hdr_q[cnt_q[6:2]][15:8]  <= load_data;
                default: hdr_q[cnt_q[6:2]][7:0] <= load_data;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        nonce_d = nonce_q;
        hit_d   = hit_q;

        case (state_q)
            IDLE: begin
                if (load_fire) begin
                    cnt_d = cnt_q + 7'd1;
                    if (cnt_q >= 7'd76) begin
                        case (cnt_q[1:0])
                            2'd0: nonce_d[31:24] = load_data;
                            2'd1: nonce_d[23:16] = load_data;
                            2'd2: nonce_d[15:8]  = load_data;
                            default: nonce_d[7:0] = load_data;
                        endcase
                    end
                    if (cnt_q == 7'd79) state_d = READY;
                end
            end
            READY: if (go) state_d = ARM;
            ARM:   state_d = HASH;
            HASH: begin
                if (h_done) begin
                    hit_d   = ((h_hash & hit_mask) == '0);
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (hit_q) begin
                    state_d = FOUND;
                end else if (at_last) begin
                    state_d = EXHAUSTED;
                end else begin
                    nonce_d = nonce_q + NONCE_STEP;
                    state_d = ARM;
                end
            end
            FOUND: begin
                // Resume: same step rule as a miss, the found nonce is skipped.
                if (go) begin
                    if (at_last) begin
                        state_d = EXHAUSTED;
                    end else begin
                        nonce_d = nonce_q + NONCE_STEP;
                        state_d = ARM;
                    end
                end
            end
            EXHAUSTED: state_d = EXHAUSTED;
            default:   state_d = IDLE;
        endcase

        // Clear overrides whatever the state logic chose, including go.
        if (clear && (state_q != IDLE)) begin
            state_d = IDLE;
            cnt_d   = 7'd0;
        end
    end

    always_comb begin
        word_sel = 32'h0;
        if (h_addr < 5'd19) begin
            word_sel = hdr_q[h_addr];
        end else if (h_addr == 5'd19) begin
            word_sel = nonce_q;
        end
    end

    // Only a fresh rising edge of h_rq is answered; a held request is not.
    always_comb begin
        h_rdy_d  = (state_q == HASH) && h_rq && !rq_prev_q;
        h_data_d = h_rdy_d ? word_sel : h_data_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= 7'd0;
            nonce_q   <= 32'h0;
            hit_q     <= 1'b0;
            rq_prev_q <= 1'b0;
            h_rdy_q   <= 1'b0;
            h_data_q  <= 32'h0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            nonce_q   <= nonce_d;
            hit_q     <= hit_d;
            rq_prev_q <= h_rq;
            h_rdy_q   <= h_rdy_d;
            h_data_q  <= h_data_d;
        end
    end

    assign load_ready = (state_q == IDLE);
    assign h_start    = (state_q == ARM);
    assign busy       = (state_q == ARM) || (state_q == HASH) || (state_q == CHECK);
    assign found      = (state_q == FOUND);
    assign exhausted  = (state_q == EXHAUSTED);
    assign nonce      = nonce_q;
    assign h_rdy      = h_rdy_q;
    assign h_data     = h_data_q;

endmodule

// File: tb/tb_nonce_feeder.sv
// Bench for nonce_feeder: a sequential hasher model drives word requests and
// results; expected served words are queued when a request is issued and
// compared when h_rdy comes back.
module tb_nonce_feeder;

    logic         clk = 1'b0;
    logic         rst, load_valid, go, clear, h_rq, h_done;
    logic [7:0]   load_data, zbits;
    logic [4:0]   h_addr;
    logic [255:0] h_hash;
    logic         load_ready, h_start, h_rdy, found, exhausted, busy;
    logic [31:0]  h_data, nonce;

    nonce_feeder dut (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_data(load_data),
        .load_ready(load_ready), .go(go), .clear(clear), .zbits(zbits),
        .h_start(h_start), .h_rq(h_rq), .h_addr(h_addr), .h_data(h_data),
        .h_rdy(h_rdy), .h_hash(h_hash), .h_done(h_done), .found(found),
        .exhausted(exhausted), .busy(busy), .nonce(nonce)
    );

    always #5 clk = ~clk;

    int errs = 0;
    int nchk = 0;
    int starts = 0;
    logic [7:0]  hdr [80];
    logic [31:0] exp_q [$];

    localparam logic [255:0] ONES = {256{1'b1}};

    always @(negedge clk) if (h_start) starts++;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] hword(input int k);
        return {hdr[4*k], hdr[4*k+1], hdr[4*k+2], hdr[4*k+3]};
    endfunction

    task automatic load_hdr();
        for (int i = 0; i < 80; i++) begin
            load_valid = 1'b1;
            load_data  = hdr[i];
            tick();
        end
        load_valid = 1'b0;
    endtask

    // Issue one word request; expect h_rdy exactly one cycle after the edge.
    task automatic hreq(input logic [4:0] a, input logic [31:0] e, input string tag);
        int lat = 0;
        h_addr = a;
        h_rq   = 1'b1;
        exp_q.push_back(e);
        tick();
        while (!h_rdy && lat < 4) begin
            tick();
            lat++;
        end
        chk({tag, "_lat"}, lat, 0);
        if (h_rdy) chk(tag, h_data, exp_q.pop_front());
        else exp_q.delete();
        h_rq = 1'b0;
        tick();
    endtask

    task automatic wait_start(input string tag, input int maxc);
        int n = 0;
        while (!h_start && n < maxc) begin
            tick();
            n++;
        end
        chk(tag, {31'b0, h_start}, 32'd1);
        tick();
    endtask

    task automatic finish_hash(input logic [255:0] hv);
        h_hash = hv;
        h_done = 1'b1;
        tick();
        h_done = 1'b0;
    endtask

    task automatic wait_flag(input string tag, input bit want_found);
        int n = 0;
        while (!(want_found ? found : exhausted) && n < 6) begin
            tick();
            n++;
        end
        chk(tag, {31'b0, (want_found ? found : exhausted)}, 32'd1);
    endtask

    task automatic go_pulse();
        go = 1'b1;
        tick();
        go = 1'b0;
    endtask

    initial begin
        int s0, pulses, first;
        logic [31:0] init;
        rst = 1'b1; load_valid = 0; load_data = 0; go = 0; clear = 0;
        zbits = 0; h_rq = 0; h_addr = 0; h_hash = '0; h_done = 0;
        tick(); tick();
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_found", {31'b0, found}, 0);
        chk("rst_exh", {31'b0, exhausted}, 0);
        chk("rst_nonce", nonce, 0);
        chk("rst_hrdy", {31'b0, h_rdy}, 0);
        chk("rst_hdata", h_data, 0);
        chk("rst_hstart", {31'b0, h_start}, 0);
        rst = 1'b0;
        tick();
        chk("ready_after_rst", {31'b0, load_ready}, 1);

        // Basic job: bytes 0x00..0x4F, zbits=0 always hits.
        for (int i = 0; i < 80; i++) hdr[i] = 8'(i);
        go = 1'b1; tick(); go = 1'b0;           // go ignored in IDLE
        chk("go_in_idle", {31'b0, load_ready}, 1);
        load_hdr();
        chk("ready_low", {31'b0, load_ready}, 0);
        chk("init_nonce", nonce, 32'h4C4D4E4F);
        h_rq = 1'b1; h_addr = 0; tick(); tick();
        chk("rq_outside_hash", {31'b0, h_rdy}, 0);
        h_rq = 1'b0; tick();
        s0 = starts;
        zbits = 8'd0;
        go_pulse();
        wait_start("start1", 4);
        chk("busy_hash", {31'b0, busy}, 1);
        hreq(5'd0, 32'h00010203, "w0");
        hreq(5'd19, 32'h4C4D4E4F, "w19");
        hreq(5'd25, 32'h00000000, "w25");
        finish_hash(ONES);
        wait_flag("found1", 1'b1);
        chk("nonce1", nonce, 32'h4C4D4E4F);
        chk("starts1", starts - s0, 1);

        // Resume from FOUND: step to nonce+1 and hash again.
        go_pulse();
        chk("found_cleared", {31'b0, found}, 0);
        wait_start("start_resume", 2);
        hreq(5'd19, 32'h4C4D4E50, "w19_resume");
        finish_hash(ONES);
        wait_flag("found2", 1'b1);
        chk("nonce2", nonce, 32'h4C4D4E50);
        clear = 1'b1; go = 1'b1; tick(); clear = 1'b0; go = 1'b0;
        chk("clear_idle", {31'b0, load_ready}, 1);
        chk("clear_found", {31'b0, found}, 0);

        // zbits=8 sweep: two misses then a hit.
        for (int i = 0; i < 80; i++) hdr[i] = 8'(i * 3 + 7);
        init = hword(19);
        load_hdr();
        chk("init_nonce2", nonce, init);
        zbits = 8'd8;
        s0 = starts;
        go_pulse();
        for (int j = 0; j < 3; j++) begin
            wait_start("start_sweep", 5);
            if (j == 1) hreq(5'd7, hword(7), "w7");
            hreq(5'd19, init + 32'(j), "w19_sweep");
            finish_hash(j < 2 ? {8'h01, 248'h0} : {8'h00, {248{1'b1}}});
        end
        wait_flag("found_sweep", 1'b1);
        chk("nonce_sweep", nonce, init + 32'd2);
        chk("starts_sweep", starts - s0, 3);
        clear = 1'b1; tick(); clear = 1'b0;

        // Exhaustion at the top of the nonce space.
        for (int i = 0; i < 80; i++) hdr[i] = 8'(i);
        hdr[76] = 8'hFF; hdr[77] = 8'hFF; hdr[78] = 8'hFF; hdr[79] = 8'hFE;
        load_hdr();
        zbits = 8'd255;
        s0 = starts;
        go_pulse();
        wait_start("start_ex0", 4);
        hreq(5'd19, 32'hFFFFFFFE, "w19_ex0");
        finish_hash(ONES);
        wait_start("start_ex1", 4);
        hreq(5'd19, 32'hFFFFFFFF, "w19_ex1");
        finish_hash(ONES);
        wait_flag("exhausted", 1'b0);
        go = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        go = 1'b0;
        chk("exh_hold", {31'b0, exhausted}, 1);
        chk("exh_nonce", nonce, 32'hFFFFFFFF);
        chk("exh_starts", starts - s0, 2);
        clear = 1'b1; tick(); clear = 1'b0;
        chk("exh_clear", {31'b0, exhausted}, 0);
        chk("exh_clear_rdy", {31'b0, load_ready}, 1);

        // Held h_rq, bytes offered in HASH, then reset mid-HASH.
        for (int i = 0; i < 80; i++) hdr[i] = 8'(8'hA0 ^ i);
        load_hdr();
        zbits = 8'd0;
        go_pulse();
        wait_start("start_hold", 4);
        h_rq = 1'b1; h_addr = 5'd19;
        exp_q.push_back(hword(19));
        pulses = 0; first = -1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (h_rdy) begin
                if (first < 0) begin
                    first = i;
                    chk("hold_data", h_data, exp_q.pop_front());
                end
                pulses++;
            end
        end
        h_rq = 1'b0; tick();
        chk("hold_pulses", pulses, 1);
        chk("hold_first", first, 0);
        exp_q.delete();
        load_valid = 1'b1; load_data = 8'hEE;
        tick(); tick(); tick();
        hreq(5'd0, hword(0), "w0_after_offer");
        hreq(5'd18, hword(18), "w18_after_offer");
        hreq(5'd19, hword(19), "w19_after_offer");
        rst = 1'b1; load_valid = 1'b1; load_data = 8'h55; h_rq = 1'b1;
        tick();
        rst = 1'b0; load_valid = 1'b0; h_rq = 1'b0;
        chk("midrst_busy", {31'b0, busy}, 0);
        chk("midrst_hrdy", {31'b0, h_rdy}, 0);
        chk("midrst_ready", {31'b0, load_ready}, 1);
        chk("midrst_nonce", nonce, 0);

        $display("Result: errors=%0d of %0d checks", errs, nchk);
        $finish;
    end

endmodule

// File: doc/nonce_feeder.md
NONCE_FEEDER -- requirements
Module: nonce_feeder

Interface
REQ-001 SHALL have parameter NONCE_STEP, default 1, meaning the increment applied to the nonce after each miss (32-bit unsigned, nonzero).
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset: synchronous and active-high.
REQ-004 SHALL have port load_valid, input, 1, meaning the host header byte is valid.
REQ-005 SHALL have port load_data, input, 8, carrying the host header byte.
REQ-006 SHALL have port load_ready, output, 1, meaning the block accepts header bytes.
REQ-007 SHALL have port go, input, 1, which starts or resumes the nonce sweep.
REQ-008 SHALL have port clear, input, 1, which abandons the job and returns to header load.
REQ-009 SHALL have port zbits, input, 8, giving the number of required leading zero hash bits.
REQ-010 SHALL have port h_start, output, 1, a one-cycle start pulse to the double-SHA256 hasher.
REQ-011 SHALL have ports h_rq (input, 1) and h_addr (input, 5), carrying the hasher word request and the requested word index.
REQ-012 SHALL have ports h_data (output, 32) and h_rdy (output, 1), carrying the served word and its one-cycle valid strobe.
REQ-013 SHALL have ports h_hash (input, 256) and h_done (input, 1), carrying the hasher result (bit 255 = MSB) and its completion flag.
REQ-014 SHALL have ports found (output, 1), exhausted (output, 1), busy (output, 1) and nonce (output, 32), giving job status and the current nonce.

Function
REQ-015 SHALL implement states IDLE, READY, ARM, HASH, CHECK, FOUND, EXHAUSTED.
REQ-016 SHALL drive load_ready = 1 only in IDLE, and SHALL store a byte on each cycle with load_valid && load_ready, in order, into bytes 0..79.
REQ-017 SHALL pack bytes big-endian: word k = {byte 4k, 4k+1, 4k+2, 4k+3}.
REQ-018 SHALL copy bytes 76..79 into the nonce register as the initial nonce, and SHALL go IDLE->READY on acceptance of byte 79.
REQ-019 SHALL ignore load_valid outside IDLE, and SHALL ignore go in IDLE.
REQ-020 SHALL go READY->ARM on go; in ARM it SHALL assert h_start for exactly one cycle, then enter HASH.
REQ-021 SHALL, in HASH, detect rising edges of h_rq (h_rq=1, previous h_rq=0), and respond to each on the next cycle with h_rdy=1 for exactly one cycle and h_data valid that same cycle.
REQ-022 SHALL serve header words 0..18 for h_addr 0..18, the nonce register for h_addr 19, and 0x00000000 for h_addr 20..31.
REQ-023 SHALL ignore h_rq edges outside HASH, and SHALL hold h_rdy low when h_rq is held high.
REQ-024 SHALL go HASH->CHECK on h_done=1 and register hit = (h_hash[255 -: zbits] all zero); zbits=0 always hits.
REQ-025 SHALL, in CHECK with hit, go to FOUND and set found=1.
REQ-026 SHALL, in CHECK with a miss and nonce > 0xFFFFFFFF-NONCE_STEP, go to EXHAUSTED and set exhausted=1, with the nonce unchanged.
REQ-027 SHALL, in CHECK otherwise, set nonce += NONCE_STEP and go to ARM; CHECK SHALL last exactly one cycle.
REQ-028 SHALL, in FOUND, on go: clear found, apply the REQ-026/027 step rule, and continue.
REQ-029 SHALL hold EXHAUSTED until clear.
REQ-030 SHALL, on clear in any non-IDLE state, go to IDLE, zero the byte counter and clear found/exhausted; clear SHALL win over simultaneous go.
REQ-031 SHALL assert busy = 1 in ARM, HASH and CHECK.
REQ-032 SHALL present nonce = the nonce register at all times; it SHALL be stable in FOUND/EXHAUSTED.

Reset
REQ-033 SHALL, on rst=1 at a clock edge, enter IDLE with: byte counter 0, nonce 0, h_start 0, h_rdy 0, h_data 0, found 0, exhausted 0, busy 0, previous-h_rq flag 0.
REQ-034 SHALL not require header storage to be cleared by reset.
REQ-035 SHALL have load_ready=1 on the first cycle after rst deasserts.
REQ-036 SHALL give rst priority over clear, go and load_valid, including mid-HASH.

Verification
REQ-037 SHALL cover: load bytes 0x00..0x4F, zbits=0, go, hasher model requests addr 0,19,25 -> h_data 0x00010203, 0x4C4D4E4F, 0x00000000; one h_start; found=1, nonce=0x4C4D4E4F.
REQ-038 SHALL cover: zbits=8, model hashes with top byte 0x01, 0x01, 0x00 -> three h_start pulses, found=1, nonce=initial+2, word 19 served as initial, +1, +2.
REQ-039 SHALL cover: initial nonce 0xFFFFFFFE, zbits=255, all-ones hashes -> two hashes, exhausted=1, nonce=0xFFFFFFFF, no third h_start.
REQ-040 SHALL cover: FOUND then go -> found=0, next h_start within 2 cycles, word 19 = nonce+1.
REQ-041 SHALL cover: h_rq held high 10 cycles -> exactly one h_rdy pulse, 1 cycle after the rising edge.
REQ-042 SHALL cover: rst pulse mid-HASH with load_valid=1 -> next cycle busy=0, h_rdy=0, load_ready=1; bytes offered while in HASH not stored.
